// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared constants, FSM state type and SCCB line-level helper
// for the OV7670 configuration sequencer.
//   SCCB_DEV_ID : OV7670 write address
//   ROM_END     : end-of-sequence ROM marker
//   ROM_DELAY   : upper byte of a "wait n ms" ROM entry
//   FRAME_BITS  : ID, X, reg, X, val, X
package ov7670_pkg;

  localparam logic [7:0]  SCCB_DEV_ID = 8'h42;
  localparam logic [15:0] ROM_END     = 16'hFFFF;
  localparam logic [7:0]  ROM_DELAY   = 8'hF0;
  localparam int          FRAME_BITS  = 27;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    BITS,
    STOP,
    GAP,
    DELAY,
    DONE
  } sccb_state_t;

  // Returns {sioc, siod_oe} for a bus element at quarter qph.
  // A data bit drives oe = ~bit for the whole element, so SIOD only moves
  // together with the sioc falling edge at q0.
  function automatic logic [1:0] bus_level(input sccb_state_t st,
                                           input logic [1:0]  qph,
                                           input logic        bit_val);
    logic [1:0] lv;
    lv = 2'b10;
    case (st)
      START: begin
        case (qph)
          2'd0:    lv = 2'b10;
          2'd3:    lv = 2'b01;
          default: lv = 2'b11;
        endcase
      end
      BITS: lv = {qph[1], ~bit_val};
      STOP: begin
        case (qph)
          2'd0:    lv = 2'b01;
          2'd1:    lv = 2'b11;
          default: lv = 2'b10;
        endcase
      end
      default: lv = 2'b10;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/ov7670_sccb_config_if.sv
// ov7670_sccb_config_if: control and SCCB pin bundle of the sequencer.
//   start       : restart request pulse (into the sequencer)
//   sioc        : SCCB clock, idle high
//   siod_oe     : 1 pulls SIOD low, 0 releases it
//   busy        : sequence in progress
//   config_done : end marker reached
//   cfg_index   : ROM index being executed
interface ov7670_sccb_config_if;
  logic       start;
  logic       sioc;
  logic       siod_oe;
  logic       busy;
  logic       config_done;
  logic [7:0] cfg_index;

  modport master (
    input  start,
    output sioc, siod_oe, busy, config_done, cfg_index
  );

  modport slave (
    output start,
    input  sioc, siod_oe, busy, config_done, cfg_index
  );
endinterface

// File: rtl/ov7670_reg_rom.sv
// ov7670_reg_rom: combinational register table, 8-bit index -> {reg, val}.
//   ROM_SEL 0 : RGB565 / VGA setting list used with ov7670_capture
//   ROM_SEL 1 : short two-write table for bring-up
//   ROM_SEL 2 : delay-then-write table for bring-up
//   index : entry number
//   entry : 16-bit entry; FFFF ends, F0nn waits nn ms
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter int ROM_SEL = 0
) (
  input  logic [7:0]  index,
  output logic [15:0] entry
);

  if (ROM_SEL == 1) begin : g_rom_short
    always_comb begin
      case (index)
        8'd0:    entry = 16'h1280;
        8'd1:    entry = 16'h1140;
        default: entry = ROM_END;
      endcase
    end
  end else if (ROM_SEL == 2) begin : g_rom_delay
    always_comb begin
      case (index)
        8'd0:    entry = 16'hF002;
        8'd1:    entry = 16'h3A04;
        default: entry = ROM_END;
      endcase
    end
  end else begin : g_rom_rgb565_vga
    always_comb begin
      case (index)
        8'd0:    entry = 16'h1280;  // COM7: soft reset
        8'd1:    entry = 16'hF00A;  // let the sensor come out of reset
        8'd2:    entry = 16'h1204;  // COM7: RGB output
        8'd3:    entry = 16'h1180;  // CLKRC
        8'd4:    entry = 16'h0C00;  // COM3
        8'd5:    entry = 16'h3E00;  // COM14
        8'd6:    entry = 16'h40D0;  // COM15: RGB565, full range
        8'd7:    entry = 16'h8C00;  // RGB444 off
        8'd8:    entry = 16'h0400;  // COM1
        8'd9:    entry = 16'h3A04;  // TSLB
        8'd10:   entry = 16'h1438;  // COM9: gain ceiling
        8'd11:   entry = 16'h4FB3;  // colour matrix
        8'd12:   entry = 16'h50B3;
        8'd13:   entry = 16'h5100;
        8'd14:   entry = 16'h523D;
        8'd15:   entry = 16'h53A7;
        8'd16:   entry = 16'h54E4;
        8'd17:   entry = 16'h589E;
        8'd18:   entry = 16'h3DC0;  // COM13
        8'd19:   entry = 16'h1714;  // HSTART
        8'd20:   entry = 16'h1802;  // HSTOP
        8'd21:   entry = 16'h3280;  // HREF
        8'd22:   entry = 16'h1903;  // VSTART
        8'd23:   entry = 16'h1A7B;  // VSTOP
        8'd24:   entry = 16'h030A;  // VREF
        8'd25:   entry = 16'h0F41;  // COM6
        8'd26:   entry = 16'h1E00;  // MVFP
        8'd27:   entry = 16'h330B;
        8'd28:   entry = 16'h3C78;  // COM12
        8'd29:   entry = 16'h6900;
        8'd30:   entry = 16'h7400;
        8'd31:   entry = 16'hB084;
        8'd32:   entry = 16'hB10C;
        8'd33:   entry = 16'hB20E;
        8'd34:   entry = 16'hB380;
        8'd35:   entry = 16'h13E7;  // COM8: AGC/AEC/AWB on
        default: entry = ROM_END;
      endcase
    end
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config: walks the register ROM after reset or on start and
// issues one SCCB 3-phase write (ID, reg, val) per entry, honouring
// in-ROM millisecond delays.
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : start in; sioc, siod_oe, busy, config_done, cfg_index out
// QUARTER = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) must be at least 2.
module ov7670_sccb_config
  import ov7670_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int SCCB_FREQ_HZ = 100_000,
  parameter int AUTO_START   = 1,
  parameter int MS_CYCLES    = CLK_FREQ_HZ / 1000,
  parameter int ROM_SEL      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  ov7670_sccb_config_if.master        bus
);

  localparam int QUARTER = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int QW      = $clog2(QUARTER);
  localparam int MW      = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam logic [QW-1:0] Q_RELOAD  = QW'(QUARTER - 1);
  localparam logic [MW-1:0] MS_RELOAD = MW'(MS_CYCLES - 1);
  localparam logic [4:0]    LAST_BIT  = 5'(FRAME_BITS - 1);

  sccb_state_t     state_q, state_n;
  logic [1:0]      qph_q, qph_n;
  logic [QW-1:0]   q_tmr_q, q_tmr_n;
  logic [4:0]      bit_cnt_q, bit_cnt_n;
  logic [26:0]     shreg_q, shreg_n;
  logic [7:0]      dly_n_q, dly_n_n;
  logic [MW-1:0]   ms_tmr_q, ms_tmr_n;
  logic [7:0]      idx_q, idx_n;
  logic            auto_q, auto_n;
  logic            sioc_q, oe_q, busy_q, done_q;
  logic [1:0]      lvl_n;
  logic [15:0]     rom_entry;
  logic            q_tick, elem_end;

  ov7670_reg_rom #(.ROM_SEL(ROM_SEL)) u_rom (
    .index (idx_q),
    .entry (rom_entry)
  );

  assign q_tick   = (q_tmr_q == '0);
  assign elem_end = q_tick && (qph_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      qph_q     <= 2'd0;
      q_tmr_q   <= '0;
      bit_cnt_q <= 5'd0;
      shreg_q   <= '0;
      dly_n_q   <= 8'd0;
      ms_tmr_q  <= '0;
      idx_q     <= 8'd0;
      auto_q    <= (AUTO_START != 0);
      sioc_q    <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      qph_q     <= qph_n;
      q_tmr_q   <= q_tmr_n;
      bit_cnt_q <= bit_cnt_n;
      shreg_q   <= shreg_n;
      dly_n_q   <= dly_n_n;
      ms_tmr_q  <= ms_tmr_n;
      idx_q     <= idx_n;
      auto_q    <= auto_n;
      sioc_q    <= lvl_n[1];
      oe_q      <= lvl_n[0];
      busy_q    <= (state_n != IDLE) && (state_n != DONE);
      done_q    <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n   = state_q;
    qph_n     = qph_q;
    q_tmr_n   = q_tmr_q;
    bit_cnt_n = bit_cnt_q;
    shreg_n   = shreg_q;
    dly_n_n   = dly_n_q;
    ms_tmr_n  = ms_tmr_q;
    idx_n     = idx_q;
    auto_n    = auto_q;

    // All bus elements share one quarter timer; qph wraps 3 -> 0 at element end.
    if (state_q inside {START, BITS, STOP, GAP}) begin
      if (q_tick) begin
        q_tmr_n = Q_RELOAD;
        qph_n   = qph_q + 2'd1;
      end else begin
        q_tmr_n = q_tmr_q - 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start || auto_q) begin
          state_n = FETCH;
          idx_n   = 8'd0;
          auto_n  = 1'b0;
        end
      end
      FETCH: begin
        if (rom_entry == ROM_END) begin
          state_n = DONE;
        end else if (rom_entry[15:8] == ROM_DELAY) begin
          state_n  = DELAY;
          dly_n_n  = rom_entry[7:0];
          ms_tmr_n = MS_RELOAD;
        end else begin
          state_n   = START;
          qph_n     = 2'd0;
          q_tmr_n   = Q_RELOAD;
          bit_cnt_n = 5'd0;
          // A 1 in each don't-care slot maps to oe = 0 (SIOD released).
          shreg_n   = {SCCB_DEV_ID, 1'b1, rom_entry[15:8], 1'b1, rom_entry[7:0], 1'b1};
        end
      end
      START: begin
        if (elem_end) state_n = BITS;
      end
      BITS: begin
        if (elem_end) begin
          shreg_n = {shreg_q[25:0], 1'b0};
          if (bit_cnt_q == LAST_BIT) begin
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (elem_end) state_n = GAP;
      end
      GAP: begin
        if (elem_end) begin
          state_n = FETCH;
          idx_n   = idx_q + 8'd1;
          q_tmr_n = '0;
          qph_n   = 2'd0;
        end
      end
      DELAY: begin
        if ((dly_n_q == 8'd0) || ((ms_tmr_q == '0) && (dly_n_q == 8'd1))) begin
          state_n = FETCH;
          idx_n   = idx_q + 8'd1;
        end else if (ms_tmr_q == '0) begin
          ms_tmr_n = MS_RELOAD;
          dly_n_n  = dly_n_q - 8'd1;
        end else begin
          ms_tmr_n = ms_tmr_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_n = FETCH;
          idx_n   = 8'd0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Pin levels are registered from the next-state view so they stay
    // glitch-free yet line up with the state they belong to.
    lvl_n = bus_level(state_n, qph_n, shreg_n[26]);
  end

  assign bus.sioc        = sioc_q;
  assign bus.siod_oe     = oe_q;
  assign bus.busy        = busy_q;
  assign bus.config_done = done_q;
  assign bus.cfg_index   = idx_q;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
module tb_ov7670_sccb_config;

  logic clk;
  logic rst_a, rst_b;
  logic sel;

  ov7670_sccb_config_if ifa ();
  ov7670_sccb_config_if ifb ();

  ov7670_sccb_config #(
    .CLK_FREQ_HZ(4000), .SCCB_FREQ_HZ(100), .AUTO_START(1), .MS_CYCLES(4), .ROM_SEL(1)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa.master)
  );

  ov7670_sccb_config #(
    .CLK_FREQ_HZ(4000), .SCCB_FREQ_HZ(100), .AUTO_START(0), .MS_CYCLES(4), .ROM_SEL(2)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected {id, reg, val} frames.
  logic [23:0] sb[$];

  // SCCB monitor on the selected DUT, sampled on the falling clk edge.
  logic        m_sioc, m_oe, m_rst;
  assign m_sioc = sel ? ifb.sioc    : ifa.sioc;
  assign m_oe   = sel ? ifb.siod_oe : ifa.siod_oe;
  assign m_rst  = sel ? rst_b       : rst_a;

  int          mcyc = 0;
  int          m_last_rise = 0;
  int          m_rises = 0;
  int          m_frames = 0;
  logic        m_in_frame = 1'b0;
  logic        m_x_win = 1'b0;
  logic        m_x_bad = 1'b0;
  logic        m_sioc_p = 1'b1;
  logic        m_line_p = 1'b1;
  logic [26:0] m_shv = '0;

  always @(negedge clk) begin
    logic line;
    logic fall, rise;
    logic [23:0] got, exp;
    mcyc++;
    if (!m_rst) begin
      m_in_frame = 1'b0;
      m_x_win    = 1'b0;
      m_x_bad    = 1'b0;
      m_rises    = 0;
      m_sioc_p   = 1'b1;
      m_line_p   = 1'b1;
    end else begin
      fall = m_sioc_p && !m_sioc;
      rise = !m_sioc_p && m_sioc;
      // Bench pulls SIOD low for the whole don't-care slot, like an ACK.
      if (fall) m_x_win = m_in_frame && (m_rises == 8 || m_rises == 17 || m_rises == 26);
      line = !(m_oe || m_x_win);
      if (m_in_frame && m_x_win && m_oe) m_x_bad = 1'b1;
      if (m_sioc_p && m_sioc && (line != m_line_p)) begin
        if (!line) begin
          check("start_outside_frame", {31'd0, m_in_frame}, 32'd0);
          m_in_frame = 1'b1;
          m_rises    = 0;
          m_x_bad    = 1'b0;
        end else begin
          check("stop_bit_count", m_rises, 27);
          check("xbit_oe_released", {31'd0, m_x_bad}, 32'd0);
          got = {m_shv[26:19], m_shv[17:10], m_shv[8:1]};
          check("sb_has_entry", {31'd0, (sb.size() > 0)}, 32'd1);
          if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("frame_id_reg_val", {8'd0, got}, {8'd0, exp});
          end
          m_frames++;
          m_in_frame = 1'b0;
        end
      end
      if (rise && m_in_frame && m_rises < 27) begin
        if (m_rises > 0) check("sioc_period", mcyc - m_last_rise, 40);
        m_last_rise = mcyc;
        m_shv       = {m_shv[25:0], line};
        m_rises++;
      end
      m_sioc_p = m_sioc;
      m_line_p = line;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at, busy_at, fall_at;
    logic found;

    rst_a = 1'b0;
    rst_b = 1'b0;
    sel   = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;

    // Reset state and auto-start sequence on the two-write ROM.
    sb.push_back(24'h421280);
    sb.push_back(24'h421140);
    repeat (5) @(negedge clk);
    check("rst_sioc", {31'd0, ifa.sioc}, 32'd1);
    check("rst_siod_oe", {31'd0, ifa.siod_oe}, 32'd0);
    check("rst_busy", {31'd0, ifa.busy}, 32'd0);
    check("rst_config_done", {31'd0, ifa.config_done}, 32'd0);
    check("rst_cfg_index", {24'd0, ifa.cfg_index}, 32'd0);

    rst_a   = 1'b1;
    done_at = 0;
    for (int i = 1; i <= 5000 && done_at == 0; i++) begin
      ifa.start = (i == 300);  // busy at this point: must be ignored
      @(negedge clk);
      if (i == 1) check("auto_start_busy", {31'd0, ifa.busy}, 32'd1);
      if (ifa.config_done) done_at = i;
    end
    ifa.start = 1'b0;
    check("done_latency", done_at, 2404);
    check("done_busy_low", {31'd0, ifa.busy}, 32'd0);
    check("done_cfg_index", {24'd0, ifa.cfg_index}, 32'd2);
    check("frames_after_seq1", m_frames, 2);
    check("sb_drained_seq1", sb.size(), 0);

    // Restart from DONE replays from index 0.
    sb.push_back(24'h421280);
    sb.push_back(24'h421140);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    check("restart_done_cleared", {31'd0, ifa.config_done}, 32'd0);
    check("restart_busy", {31'd0, ifa.busy}, 32'd1);
    check("restart_index0", {24'd0, ifa.cfg_index}, 32'd0);
    done_at = 0;
    for (int i = 1; i <= 5000 && done_at == 0; i++) begin
      @(negedge clk);
      if (ifa.config_done) done_at = i;
    end
    check("replay_done_latency", done_at, 2403);
    check("frames_after_replay", m_frames, 4);

    // Reset during bit 13 of the first write, then a clean auto-start run.
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (m_in_frame && m_rises == 13 && !ifa.sioc) found = 1'b1;
    end
    check("reached_bit13", {31'd0, found}, 32'd1);
    rst_a = 1'b0;
    @(negedge clk);
    check("midrst_sioc", {31'd0, ifa.sioc}, 32'd1);
    check("midrst_siod_oe", {31'd0, ifa.siod_oe}, 32'd0);
    check("midrst_busy", {31'd0, ifa.busy}, 32'd0);
    check("midrst_cfg_index", {24'd0, ifa.cfg_index}, 32'd0);
    check("frames_after_abort", m_frames, 4);
    repeat (3) @(negedge clk);
    sb.push_back(24'h421280);
    sb.push_back(24'h421140);
    rst_a   = 1'b1;
    done_at = 0;
    for (int i = 1; i <= 5000 && done_at == 0; i++) begin
      @(negedge clk);
      if (ifa.config_done) done_at = i;
    end
    check("post_reset_done_latency", done_at, 2404);
    check("frames_after_reset_run", m_frames, 6);
    check("sb_drained_reset_run", sb.size(), 0);

    // Delay ROM on the second instance, started by pulse.
    sel = 1'b1;
    sb.push_back(24'h423A04);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);
    check("no_auto_start_busy", {31'd0, ifb.busy}, 32'd0);
    ifb.start = 1'b1;
    busy_at = 0;
    fall_at = 0;
    for (int i = 1; i <= 500 && fall_at == 0; i++) begin
      @(negedge clk);
      ifb.start = 1'b0;
      if (ifb.busy && busy_at == 0) busy_at = i;
      if (!ifb.sioc && fall_at == 0) fall_at = i;
    end
    check("delay_busy_rise", busy_at, 1);
    check("delay_first_sioc_fall", fall_at - busy_at, 40);
    done_at = 0;
    for (int i = 1; i <= 3000 && done_at == 0; i++) begin
      @(negedge clk);
      if (ifb.config_done) done_at = i;
    end
    check("delay_rom_done", {31'd0, ifb.config_done}, 32'd1);
    check("delay_rom_cfg_index", {24'd0, ifb.cfg_index}, 32'd2);
    check("frames_after_delay_rom", m_frames, 7);
    check("sb_drained_delay_rom", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
